// File: rtl/deser_stage.sv
// deser_stage: serial-to-parallel deserializer with start-of-frame alignment,
// a single-entry output register with valid/ready handshake, a sticky
// overflow flag for dropped words and a running count of loaded words.
module deser_stage #(
   parameter int N         = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         sin_valid,
   input  logic         sin_data,
   input  logic         sin_sof,
   output logic [N-1:0] q,
   output logic         q_valid,
   input  logic         q_ready,
   output logic         overflow,
   output logic [15:0]  word_count
);

   localparam int CW = $clog2(N);

   typedef enum logic {
      HUNT  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic [N-1:0]   sr, sr_nxt;
   logic           word_done;

   logic [N-1:0]   q_nxt;
   logic           q_valid_nxt;
   logic           overflow_nxt;
   logic [15:0]    word_count_nxt;

   // Frame alignment and bit assembly: next state, bit counter, shift register.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      sr_nxt    = sr;
      word_done = 1'b0;
      if (sin_valid) begin
         if (sin_sof) begin
            // A sof always restarts the word, discarding any partial one.
            state_nxt = SHIFT;
            cnt_nxt   = CW'(1);
            sr_nxt    = MSB_FIRST ? {{(N-1){1'b0}}, sin_data}
                                  : {sin_data, {(N-1){1'b0}}};
         end else if (state == SHIFT) begin
            sr_nxt = MSB_FIRST ? {sr[N-2:0], sin_data}
                               : {sin_data, sr[N-1:1]};
            if (cnt == CW'(N-1)) begin
               word_done = 1'b1;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
      end
   end

   // Output register stage: load, consume, drop-on-full and word counting.
   always_comb begin
      q_nxt          = q;
      q_valid_nxt    = q_valid;
      overflow_nxt   = overflow;
      word_count_nxt = word_count;
      if (word_done && (!q_valid || q_ready)) begin
         q_nxt          = sr_nxt;
         q_valid_nxt    = 1'b1;
         word_count_nxt = word_count + 16'd1;
      end else begin
         if (word_done) begin
            overflow_nxt = 1'b1;
         end
         if (q_valid && q_ready) begin
            q_valid_nxt = 1'b0;
         end
      end
   end

   // State register with synchronous reset; idle cycles hold everything.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= HUNT;
         cnt        <= '0;
         sr         <= '0;
         q          <= '0;
         q_valid    <= 1'b0;
         overflow   <= 1'b0;
         word_count <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         sr         <= sr_nxt;
         q          <= q_nxt;
         q_valid    <= q_valid_nxt;
         overflow   <= overflow_nxt;
         word_count <= word_count_nxt;
      end
   end

endmodule

// File: tb/tb_deser_stage.sv
// tb_deser_stage: directed scenarios plus random traffic on two deserializers
// (MSB-first and LSB-first) fed the same serial stream, each compared every
// cycle against a word-level reference model.
module tb_deser_stage;

   logic        clock;
   logic        reset;
   logic        sin_valid;
   logic        sin_data;
   logic        sin_sof;
   logic        rdy;

   logic [7:0]  q0, q1;
   logic        qv0, qv1;
   logic        ovf0, ovf1;
   logic [15:0] wc0, wc1;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   typedef struct {
      bit          infr;
      int unsigned nb;
      logic [7:0]  arr;   // arr[i] = i-th bit received since sof
      logic [7:0]  q;
      bit          qv;
      bit          ovf;
      logic [15:0] wc;
   } model_t;

   model_t m0, m1;

   bit         capture;
   logic [7:0] seen[$];

   deser_stage #(.N(8), .MSB_FIRST(1'b1)) dut_msb (
      .clock(clock), .reset(reset), .sin_valid(sin_valid), .sin_data(sin_data),
      .sin_sof(sin_sof), .q(q0), .q_valid(qv0), .q_ready(rdy),
      .overflow(ovf0), .word_count(wc0)
   );

   deser_stage #(.N(8), .MSB_FIRST(1'b0)) dut_lsb (
      .clock(clock), .reset(reset), .sin_valid(sin_valid), .sin_data(sin_data),
      .sin_sof(sin_sof), .q(q1), .q_valid(qv1), .q_ready(rdy),
      .overflow(ovf1), .word_count(wc1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: collect bits since sof; every 8th bit forms a word by position.
   function automatic model_t step(input model_t s, input bit msb, input bit rst,
                                   input bit v, input bit d, input bit sf, input bit rd);
      model_t     n;
      bit         done;
      logic [7:0] w;
      n    = s;
      done = 1'b0;
      w    = '0;
      if (rst) begin
         n.infr = 1'b0; n.nb = 0; n.arr = '0;
         n.q = '0; n.qv = 1'b0; n.ovf = 1'b0; n.wc = '0;
         return n;
      end
      if (v) begin
         if (sf) begin
            n.infr = 1'b1; n.arr = '0; n.arr[0] = d; n.nb = 1;
         end else if (s.infr) begin
            n.arr[s.nb] = d;
            n.nb = s.nb + 1;
            if (n.nb == 8) begin
               done = 1'b1;
               for (int i = 0; i < 8; i++) w[msb ? 7 - i : i] = n.arr[i];
               n.nb = 0;
            end
         end
      end
      if (done && !(s.qv && !rd)) begin
         n.q = w; n.qv = 1'b1; n.wc = s.wc + 16'd1;
      end else begin
         if (done) n.ovf = 1'b1;
         if (s.qv && rd) n.qv = 1'b0;
      end
      return n;
   endfunction

   task automatic cyc(input bit v, input bit d, input bit sf, input bit rst);
      reset     = rst;
      sin_valid = v;
      sin_data  = d;
      sin_sof   = sf;
      @(posedge clock);
      m0 = step(m0, 1'b1, rst, v, d, sf, rdy);
      m1 = step(m1, 1'b0, rst, v, d, sf, rdy);
      #1;
      check("msb_q",    {24'd0, q0},   {24'd0, m0.q});
      check("msb_qv",   {31'd0, qv0},  {31'd0, m0.qv});
      check("msb_ovf",  {31'd0, ovf0}, {31'd0, m0.ovf});
      check("msb_wc",   {16'd0, wc0},  {16'd0, m0.wc});
      check("lsb_q",    {24'd0, q1},   {24'd0, m1.q});
      check("lsb_qv",   {31'd0, qv1},  {31'd0, m1.qv});
      check("lsb_ovf",  {31'd0, ovf1}, {31'd0, m1.ovf});
      check("lsb_wc",   {16'd0, wc1},  {16'd0, m1.wc});
      if (capture && qv0) seen.push_back(q0);
   endtask

   task automatic gap(input int unsigned max_gap);
      int unsigned g;
      g = $urandom_range(max_gap, 0);
      for (int unsigned i = 0; i < g; i++) cyc(1'b0, 1'($urandom), 1'($urandom), 1'b0);
   endtask

   // Sends w first-bit-first from bit 7 down; with_sof marks the first bit.
   task automatic send_word(input logic [7:0] w, input bit with_sof, input int unsigned max_gap);
      for (int i = 7; i >= 0; i--) begin
         gap(max_gap);
         cyc(1'b1, w[i], with_sof && (i == 7), 1'b0);
      end
   endtask

   task automatic do_reset();
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      rdy       = 1'b0;
      reset     = 1'b1;
      sin_valid = 1'b0;
      sin_data  = 1'b0;
      sin_sof   = 1'b0;
      capture   = 1'b0;
      m0 = '{infr: 1'b0, nb: 0, arr: '0, q: '0, qv: 1'b0, ovf: 1'b0, wc: '0};
      m1 = m0;

      // Reset state
      do_reset();
      check("rst_q",   {24'd0, q0},   32'd0);
      check("rst_qv",  {31'd0, qv0},  32'd0);
      check("rst_wc",  {16'd0, wc0},  32'd0);
      check("rst_ovf", {31'd0, ovf0}, 32'd0);

      // Bits 1,0,1,1,0,0,1,0 after sof
      rdy = 1'b1;
      send_word(8'hB2, 1'b1, 0);
      check("seq_msb_q",  {24'd0, q0},  32'hB2);
      check("seq_lsb_q",  {24'd0, q1},  32'h4D);
      check("seq_qv",     {31'd0, qv0}, 32'd1);
      check("seq_wc",     {16'd0, wc0}, 32'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      check("seq_consumed", {31'd0, qv0}, 32'd0);

      // Second word dropped while downstream stalls
      do_reset();
      rdy = 1'b0;
      send_word(8'h11, 1'b1, 0);
      send_word(8'h22, 1'b0, 0);
      check("ovf_q",   {24'd0, q0},   32'h11);
      check("ovf_flag",{31'd0, ovf0}, 32'd1);
      check("ovf_wc",  {16'd0, wc0},  32'd1);
      rdy = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      rdy = 1'b0;
      check("ovf_drain_qv", {31'd0, qv0}, 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      check("ovf_sticky", {31'd0, ovf0}, 32'd1);

      // Partial word abandoned by a new sof
      do_reset();
      rdy = 1'b1;
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      send_word(8'hA5, 1'b1, 0);
      check("resof_q",   {24'd0, q0},   32'hA5);
      check("resof_wc",  {16'd0, wc0},  32'd1);
      check("resof_ovf", {31'd0, ovf0}, 32'd0);

      // Reset mid-word, then bits without sof assemble nothing
      do_reset();
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      send_word(8'hFF, 1'b0, 0);
      check("nosof_qv",  {31'd0, qv0},  32'd0);
      check("nosof_wc",  {16'd0, wc0},  32'd0);
      check("nosof_q",   {24'd0, q0},   32'd0);
      check("nosof_ovf", {31'd0, ovf0}, 32'd0);

      // Back-to-back words with idle gaps, one sof
      do_reset();
      rdy = 1'b1;
      capture = 1'b1;
      send_word(8'h01, 1'b1, 3);
      send_word(8'h80, 1'b0, 3);
      send_word(8'hFF, 1'b0, 3);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      capture = 1'b0;
      check("b2b_n",   seen.size(), 32'd3);
      if (seen.size() == 3) begin
         check("b2b_w0", {24'd0, seen[0]}, 32'h01);
         check("b2b_w1", {24'd0, seen[1]}, 32'h80);
         check("b2b_w2", {24'd0, seen[2]}, 32'hFF);
      end
      check("b2b_wc",  {16'd0, wc0},  32'd3);
      check("b2b_ovf", {31'd0, ovf0}, 32'd0);

      // Random traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         rdy = ($urandom_range(3, 0) != 0);
         cyc(1'($urandom_range(3, 0) != 0), 1'($urandom),
             1'($urandom_range(19, 0) == 0), 1'($urandom_range(599, 0) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/deser_stage.md
DESER_STAGE -- requirements
Module: deser_stage

Interface
REQ-001 N, default 8, parallel word width; SHALL be >= 2.
REQ-002 MSB_FIRST, default 1; 1: first serial bit of a word lands in q[N-1]; 0: first bit lands in q[0].
REQ-003 clock  input  1  sole clock, all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clock.
REQ-005 sin_valid  input  1  qualifies sin_data/sin_sof for the current cycle.
REQ-006 sin_data  input  1  serial data bit.
REQ-007 sin_sof  input  1  start-of-frame marker, meaningful only when sin_valid=1.
REQ-008 q  output  N  assembled parallel word to the downstream register stage.
REQ-009 q_valid  output  1  q holds an unconsumed word.
REQ-010 q_ready  input  1  downstream accepts q when q_valid=1.
REQ-011 overflow  output  1  sticky flag, a completed word was dropped.
REQ-012 word_count  output  16  number of words loaded into q, modulo 2^16.

Function
REQ-013 FSM states HUNT and SHIFT; internal bit counter of clog2(N) bits plus N-bit shift register.
REQ-014 Cycles with sin_valid=0 SHALL leave all state unchanged; sin_data/sin_sof are don't-care.
REQ-015 HUNT: sin_valid=1 with sin_sof=0 ignored; sin_valid=1 with sin_sof=1 stores bit as first bit of a word, bit counter=1, next state SHIFT.
REQ-016 SHIFT: each sin_valid=1 bit stored at next position per MSB_FIRST, bit counter +1.
REQ-017 SHIFT with sin_valid=1 and sin_sof=1: partial word discarded, bit taken as first bit of a new word, counter=1; no flag raised.
REQ-018 On the Nth bit the word is complete: counter returns to 0, state stays SHIFT so following bits form the next word without a new sof.
REQ-019 Completed word SHALL load into q if q_valid=0, or if q_valid=1 and q_ready=1 in the same cycle; q_valid=1 the cycle after the Nth bit is accepted (latency 1).
REQ-020 Completed word while q_valid=1 and q_ready=0: word dropped, q unchanged, overflow set to 1.
REQ-021 Handshake: q_valid=1 and q_ready=1 consumes q; q_valid=0 next cycle unless a word loads in the same cycle (REQ-019).
REQ-022 q SHALL stay stable while q_valid=1 and q_ready=0.
REQ-023 word_count SHALL increment by 1 per word loaded into q, never for dropped words, wrapping 0xFFFF -> 0x0000.
REQ-024 q_ready is ignored while q_valid=0.
REQ-025 overflow SHALL clear only through reset.

Reset
REQ-026 reset=1 at a rising edge: q=0, q_valid=0, overflow=0, word_count=0, bit counter=0, shift register=0, state HUNT.
REQ-027 reset SHALL dominate all simultaneous inputs; a partial word in progress is discarded.
REQ-028 After reset release, no word is assembled until a sin_valid=1 & sin_sof=1 bit arrives.

Verification
REQ-029 N=8, MSB_FIRST=1, q_ready=1, sof then contiguous bits 1,0,1,1,0,0,1,0 -> q=8'hB2, q_valid high exactly 1 cycle after 8th bit, word_count=1.
REQ-030 N=8, MSB_FIRST=0, same bit sequence -> q=8'h4D, word_count=1.
REQ-031 q_ready=0, two complete words 0x11 then 0x22 -> q=0x11 held stable, overflow=1, word_count=1; then q_ready=1 for one cycle -> q_valid=0 next cycle.
REQ-032 sof plus 2 bits, then sof plus 8 bits encoding 0xA5 (MSB_FIRST=1) -> exactly one word q=0xA5, overflow=0.
REQ-033 reset pulsed after 5 bits of a word, then 8 bits with no sof -> q_valid stays 0, word_count=0, all outputs 0.
REQ-034 sof, then 3 back-to-back words 0x01,0x80,0xFF with random sin_valid gaps and q_ready=1 -> three loads in order, word_count=3, overflow=0.
